// File: rtl/spi_reg_bank.sv
// Byte-level SPI command decoder and 8-bit register file driven by SPI_Slave RX bytes.
// Parses {R/W, addr} command bytes, auto-increments through registers, and returns read data on MISO.
module spi_reg_bank #(
    parameter int unsigned NUM_REGS       = 16,
    parameter logic [7:0]  IDLE_BYTE      = 8'hA5,
    parameter int unsigned CS_SYNC_STAGES = 3
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_SPI_CS_n,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    input  logic [6:0] i_Usr_Addr,
    output logic [7:0] o_Usr_Data,
    output logic       o_Wr_Strobe,
    output logic [6:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Busy,
    output logic       o_Addr_Err,
    input  logic       i_Err_Clr
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    logic [7:0]                regs [NUM_REGS];
    logic [CS_SYNC_STAGES-1:0] cs_sync;
    logic [CS_SYNC_STAGES-1:0] sync_vld;
    logic                      cs_s;
    logic                      armed;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [6:0] ptr;
    logic [6:0] ptr_nxt;
    logic [6:0] ptr_inc;
    logic [7:0] tx_byte_nxt;
    logic       tx_dv_nxt;
    logic       wr_strobe_nxt;
    logic [6:0] wr_addr_nxt;
    logic [7:0] wr_data_nxt;
    logic       addr_err_nxt;
    logic       wr_en_c;
    logic [6:0] wr_idx_c;

    function automatic logic in_range(input logic [6:0] a);
        return ({1'b0, a} < 8'(NUM_REGS));
    endfunction

    function automatic logic [7:0] rd_reg(input logic [6:0] a);
        return in_range(a) ? regs[a[AW-1:0]] : 8'h00;
    endfunction

    assign cs_s    = cs_sync[CS_SYNC_STAGES-1];
    assign ptr_inc = ptr + 7'd1;

    // CS synchronizer; armed only once CS is truly seen high, so a frame cut by reset is ignored
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cs_sync  <= '1;
            sync_vld <= '0;
            armed    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[CS_SYNC_STAGES-2:0], i_SPI_CS_n};
            sync_vld <= {sync_vld[CS_SYNC_STAGES-2:0], 1'b1};
            armed    <= armed | (sync_vld[CS_SYNC_STAGES-1] & cs_s);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        tx_byte_nxt   = o_TX_Byte;
        tx_dv_nxt     = 1'b0;
        wr_strobe_nxt = 1'b0;
        wr_addr_nxt   = o_Wr_Addr;
        wr_data_nxt   = o_Wr_Data;
        addr_err_nxt  = o_Addr_Err & ~i_Err_Clr;
        wr_en_c       = 1'b0;
        wr_idx_c      = ptr;

        case (state)
            ST_IDLE: begin
                if (!cs_s && armed) begin
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (i_RX_DV) begin
                    ptr_nxt = i_RX_Byte[6:0];
                    if (i_RX_Byte[7]) begin
                        state_nxt   = ST_READ;
                        tx_byte_nxt = rd_reg(i_RX_Byte[6:0]);
                        tx_dv_nxt   = 1'b1;
                        if (!in_range(i_RX_Byte[6:0])) begin
                            addr_err_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (i_RX_DV) begin
                    if (in_range(ptr)) begin
                        wr_en_c       = 1'b1;
                        wr_strobe_nxt = 1'b1;
                        wr_addr_nxt   = ptr;
                        wr_data_nxt   = i_RX_Byte;
                    end else begin
                        addr_err_nxt = 1'b1;
                    end
                    ptr_nxt = ptr_inc;
                end
            end
            ST_READ: begin
                if (i_RX_DV) begin
                    ptr_nxt     = ptr_inc;
                    tx_byte_nxt = rd_reg(ptr_inc);
                    tx_dv_nxt   = 1'b1;
                    if (!in_range(ptr_inc)) begin
                        addr_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A byte completing with CS rising still takes effect; only the TX byte reverts to idle
        if (state != ST_IDLE && cs_s) begin
            state_nxt   = ST_IDLE;
            tx_byte_nxt = IDLE_BYTE;
            tx_dv_nxt   = (o_TX_Byte != IDLE_BYTE);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            ptr         <= '0;
            o_TX_Byte   <= IDLE_BYTE;
            o_TX_DV     <= 1'b0;
            o_Wr_Strobe <= 1'b0;
            o_Wr_Addr   <= '0;
            o_Wr_Data   <= '0;
            o_Addr_Err  <= 1'b0;
            o_Busy      <= 1'b0;
            o_Usr_Data  <= '0;
        end else begin
            ptr         <= ptr_nxt;
            o_TX_Byte   <= tx_byte_nxt;
            o_TX_DV     <= tx_dv_nxt;
            o_Wr_Strobe <= wr_strobe_nxt;
            o_Wr_Addr   <= wr_addr_nxt;
            o_Wr_Data   <= wr_data_nxt;
            o_Addr_Err  <= addr_err_nxt;
            o_Busy      <= (state_nxt != ST_IDLE);
            o_Usr_Data  <= rd_reg(i_Usr_Addr);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (wr_en_c) begin
            regs[wr_idx_c[AW-1:0]] <= i_RX_Byte;
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: stimulus pushes expected TX bytes and write events,
// monitors pop and compare whenever the DUT pulses o_TX_DV or o_Wr_Strobe.
module tb_spi_reg_bank;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       i_SPI_CS_n;
    logic       o_TX_DV;
    logic [7:0] o_TX_Byte;
    logic [6:0] i_Usr_Addr;
    logic [7:0] o_Usr_Data;
    logic       o_Wr_Strobe;
    logic [6:0] o_Wr_Addr;
    logic [7:0] o_Wr_Data;
    logic       o_Busy;
    logic       o_Addr_Err;
    logic       i_Err_Clr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  tx_q [$];
    logic [14:0] wr_q [$];

    spi_reg_bank #(.NUM_REGS(16), .IDLE_BYTE(8'hA5), .CS_SYNC_STAGES(3)) dut (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_RX_DV    (i_RX_DV),
        .i_RX_Byte  (i_RX_Byte),
        .i_SPI_CS_n (i_SPI_CS_n),
        .o_TX_DV    (o_TX_DV),
        .o_TX_Byte  (o_TX_Byte),
        .i_Usr_Addr (i_Usr_Addr),
        .o_Usr_Data (o_Usr_Data),
        .o_Wr_Strobe(o_Wr_Strobe),
        .o_Wr_Addr  (o_Wr_Addr),
        .o_Wr_Data  (o_Wr_Data),
        .o_Busy     (o_Busy),
        .o_Addr_Err (o_Addr_Err),
        .i_Err_Clr  (i_Err_Clr)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // TX monitor
    initial begin
        forever begin
            @(negedge i_Clk);
            if (o_TX_DV === 1'b1) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected", {24'h0, o_TX_Byte}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", {24'h0, o_TX_Byte}, {24'h0, tx_q.pop_front()});
                end
            end
        end
    end

    // Write-strobe monitor
    initial begin
        forever begin
            @(negedge i_Clk);
            if (o_Wr_Strobe === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", {17'h0, o_Wr_Addr, o_Wr_Data}, 32'hFFFF_FFFF);
                end else begin
                    check("wr_event", {17'h0, o_Wr_Addr, o_Wr_Data}, {17'h0, wr_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_Clk);
        i_RX_Byte = b;
        i_RX_DV   = 1'b1;
        @(negedge i_Clk);
        i_RX_DV   = 1'b0;
        repeat (6) @(negedge i_Clk);
    endtask

    task automatic cs_low();
        @(negedge i_Clk);
        i_SPI_CS_n = 1'b0;
        repeat (6) @(negedge i_Clk);
    endtask

    task automatic cs_high();
        @(negedge i_Clk);
        i_SPI_CS_n = 1'b1;
        repeat (6) @(negedge i_Clk);
    endtask

    task automatic check_reg(input logic [6:0] a, input logic [7:0] exp);
        @(negedge i_Clk);
        i_Usr_Addr = a;
        repeat (2) @(negedge i_Clk);
        check($sformatf("usr_reg%0d", a), {24'h0, o_Usr_Data}, {24'h0, exp});
    endtask

    initial begin
        i_Rst_L    = 1'b0;
        i_RX_DV    = 1'b0;
        i_RX_Byte  = 8'h00;
        i_SPI_CS_n = 1'b1;
        i_Usr_Addr = 7'd0;
        i_Err_Clr  = 1'b0;
        repeat (3) @(negedge i_Clk);
        check("rst_tx_byte", {24'h0, o_TX_Byte}, 32'hA5);
        check("rst_busy", {31'h0, o_Busy}, 32'h0);
        check("rst_err", {31'h0, o_Addr_Err}, 32'h0);
        i_Rst_L = 1'b1;
        repeat (6) @(negedge i_Clk);
        for (int i = 0; i < 16; i++) check_reg(7'(i), 8'h00);

        // Write burst starting at 2
        wr_q.push_back({7'd2, 8'h11});
        wr_q.push_back({7'd3, 8'h22});
        wr_q.push_back({7'd4, 8'h33});
        cs_low();
        check("busy_in_frame", {31'h0, o_Busy}, 32'h1);
        send_byte(8'h02);
        check("tx_write_idle", {24'h0, o_TX_Byte}, 32'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        cs_high();
        check("busy_after_frame", {31'h0, o_Busy}, 32'h0);
        check_reg(7'd2, 8'h11);
        check_reg(7'd3, 8'h22);
        check_reg(7'd4, 8'h33);
        check_reg(7'd5, 8'h00);

        // Read burst starting at 3
        tx_q.push_back(8'h22);
        tx_q.push_back(8'h33);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hA5);
        cs_low();
        send_byte(8'h83);
        send_byte(8'hFF);
        send_byte(8'h00);
        cs_high();
        check("tx_idle_after_read", {24'h0, o_TX_Byte}, 32'hA5);
        check("err_after_read", {31'h0, o_Addr_Err}, 32'h0);

        // Range boundary: reg15 written, address 16 flagged
        wr_q.push_back({7'd15, 8'hAA});
        cs_low();
        send_byte(8'h0F);
        send_byte(8'hAA);
        send_byte(8'hBB);
        cs_high();
        check_reg(7'd15, 8'hAA);
        check_reg(7'd0, 8'h00);
        check_reg(7'd20, 8'h00);
        check("addr_err_set", {31'h0, o_Addr_Err}, 32'h1);
        @(negedge i_Clk);
        i_Err_Clr = 1'b1;
        @(negedge i_Clk);
        i_Err_Clr = 1'b0;
        @(negedge i_Clk);
        check("addr_err_clr", {31'h0, o_Addr_Err}, 32'h0);

        // Last data byte coincident with synchronized CS rise
        wr_q.push_back({7'd0, 8'h5C});
        cs_low();
        send_byte(8'h00);
        @(negedge i_Clk);
        i_SPI_CS_n = 1'b1;
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        i_RX_Byte = 8'h5C;
        i_RX_DV   = 1'b1;
        @(negedge i_Clk);
        i_RX_DV   = 1'b0;
        repeat (6) @(negedge i_Clk);
        check("busy_after_cs_edge", {31'h0, o_Busy}, 32'h0);
        check_reg(7'd0, 8'h5C);
        tx_q.push_back(8'h5C);
        tx_q.push_back(8'hA5);
        cs_low();
        send_byte(8'h80);
        cs_high();

        // Reset in the middle of a write frame; rest of the frame must be ignored
        cs_low();
        send_byte(8'h00);
        @(negedge i_Clk);
        i_Rst_L = 1'b0;
        repeat (2) @(negedge i_Clk);
        check("midrst_tx_byte", {24'h0, o_TX_Byte}, 32'hA5);
        check("midrst_busy", {31'h0, o_Busy}, 32'h0);
        i_Rst_L = 1'b1;
        repeat (4) @(negedge i_Clk);
        send_byte(8'h01);
        send_byte(8'h66);
        check("midrst_busy_after", {31'h0, o_Busy}, 32'h0);
        check("midrst_err", {31'h0, o_Addr_Err}, 32'h0);
        cs_high();
        check_reg(7'd0, 8'h00);
        check_reg(7'd1, 8'h00);
        check_reg(7'd15, 8'h00);

        // Next frame after CS returns high works normally
        wr_q.push_back({7'd1, 8'h99});
        cs_low();
        send_byte(8'h01);
        send_byte(8'h99);
        cs_high();
        check_reg(7'd1, 8'h99);

        repeat (4) @(negedge i_Clk);
        check("tx_queue_drained", 32'(tx_q.size()), 32'h0);
        check("wr_queue_drained", 32'(wr_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
